// File: rtl/reset_sequencer_pkg.sv
// Shared clock-domain bundle and reset-sequencer state encoding.
// Imported by the sequencer top and its testbench.
package sys_structs;

    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_dom_sain;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Plain flop chain used to bring an asynchronous level into the clk domain.
// No reset and no enable: the chain always samples.
module synchronization_chain #(
    parameter int CHAIN_DEPTH = 2,
    parameter int CHAIN_WIDTH = 1
) (
    input  logic                   i_clk,
    input  logic [CHAIN_WIDTH-1:0] i_data,
    output logic [CHAIN_WIDTH-1:0] o_data
);

    logic [CHAIN_WIDTH-1:0] r_stage [CHAIN_DEPTH];

    always_ff @(posedge i_clk) begin
        r_stage[0] <= i_data;
        for (int i = 1; i < CHAIN_DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_data = r_stage[CHAIN_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all domains in reset, then free them one by one
// (bit 0 first) with a fixed gap; any request re-asserts everything at once.
module reset_sequencer
    import sys_structs::*;
#(
    parameter int DOMAIN_COUNT = 4,
    parameter int SYNC_DEPTH   = 3,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_GAP    = 4
) (
    input  clk_dom_sain             clk_dom_i,
    input  logic                    async_rst_req_i,
    input  logic                    sw_rst_req_i,
    output logic [DOMAIN_COUNT-1:0] domain_rst_n_o,
    output logic                    seq_busy_o,
    output logic                    seq_done_o,
    output rst_seq_state_e          dbg_state_o
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int IDX_W = $clog2(DOMAIN_COUNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DOMAIN_COUNT - 1);

    if (DOMAIN_COUNT < 1) begin : g_bad_domain_count
        $fatal(1, "reset_sequencer: DOMAIN_COUNT must be >= 1");
    end
    if (SYNC_DEPTH < 2) begin : g_bad_sync_depth
        $fatal(1, "reset_sequencer: SYNC_DEPTH must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $fatal(1, "reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_stage_gap
        $fatal(1, "reset_sequencer: STAGE_GAP must be >= 1");
    end

    logic                    w_async_sync;
    logic                    w_req;
    logic [DOMAIN_COUNT-1:0] w_rel_mask;

    rst_seq_state_e          r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [DOMAIN_COUNT-1:0] r_dom;
    logic                    r_busy;
    logic                    r_done;

    synchronization_chain #(
        .CHAIN_DEPTH (SYNC_DEPTH),
        .CHAIN_WIDTH (1)
    ) u_sync (
        .i_clk  (clk_dom_i.clk),
        .i_data (async_rst_req_i),
        .o_data (w_async_sync)
    );

    assign w_req      = w_async_sync | sw_rst_req_i;
    // Shift instead of a variable bit-select keeps the thermometer update width-safe.
    assign w_rel_mask = DOMAIN_COUNT'(1) << r_idx;

    always_ff @(posedge clk_dom_i.clk) begin
        if (!clk_dom_i.sync_rst) begin
            r_state <= ASSERT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dom   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else if (clk_dom_i.clk_en) begin
            case (r_state)
                ASSERT: begin
                    r_dom  <= '0;
                    r_busy <= 1'b1;
                    r_done <= 1'b0;
                    if (w_req) begin
                        r_cnt <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (w_req) begin
                        r_state <= ASSERT;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_dom   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else if (r_cnt == GAP_LAST) begin
                        r_dom <= r_dom | w_rel_mask;
                        r_cnt <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_state <= RUN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (w_req) begin
                        r_state <= ASSERT;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_dom   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_dom  <= '1;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ASSERT;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_dom   <= '0;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign domain_rst_n_o = r_dom;
    assign seq_busy_o     = r_busy;
    assign seq_done_o     = r_done;
    assign dbg_state_o    = r_state;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter DOMAIN_COUNT, default 4: number of sequenced reset domains (>=1).
REQ-002 Parameter SYNC_DEPTH, default 3: flops in the async-request synchronizer (>=2).
REQ-003 Parameter HOLD_CYCLES, default 16: minimum all-domains-asserted time after the request drops (>=1).
REQ-004 Parameter STAGE_GAP, default 4: cycles between successive domain releases (>=1).
REQ-005 Port clk_dom_i, input, sys_structs::clk_dom_sain: one clock (clk), clock enable (clk_en) and reset (sync_rst); sync_rst is synchronous and active-low.
REQ-006 Port async_rst_req_i, input, 1: external reset request, active-high, asynchronous to clk.
REQ-007 Port sw_rst_req_i, input, 1: software reset request, active-high, synchronous to clk.
REQ-008 Port domain_rst_n_o, output, DOMAIN_COUNT: per-domain active-low resets; bit 0 is released first.
REQ-009 Port seq_busy_o, output, 1: high whenever any domain_rst_n_o bit is low.
REQ-010 Port seq_done_o, output, 1: high only in RUN (all domains released).

Function
REQ-011 async_rst_req_i SHALL pass through a SYNC_DEPTH-deep synchronizer that ignores clk_en and sync_rst; sw_rst_req_i bypasses it.
REQ-012 Effective request req = synchronized async_rst_req_i OR sw_rst_req_i.
REQ-013 FSM states SHALL be ASSERT, RELEASE and RUN, with a stage counter cnt and a domain index idx.
REQ-014 ASSERT: domain_rst_n_o all 0. If req, cnt<=0. Else, when cnt==HOLD_CYCLES-1, go to RELEASE with cnt<=0 and idx<=0. Otherwise cnt++.
REQ-015 RELEASE: if req, go to ASSERT with cnt<=0 and all domain_rst_n_o<=0. Else, when cnt==STAGE_GAP-1: set domain_rst_n_o[idx]<=1 and cnt<=0; if idx==DOMAIN_COUNT-1, go to RUN, else idx++. Otherwise cnt++.
REQ-016 RUN: domain_rst_n_o all 1. If req, go to ASSERT with all outputs 0 on the next edge.
REQ-017 Simultaneous events: req SHALL win over any release or transition in the same cycle.
REQ-018 Released domains SHALL form a thermometer code (bits 0..idx-1 high); no domain is released out of order.
REQ-019 clk_en low SHALL freeze the FSM, cnt, idx and all outputs; the synchronizer keeps sampling.
REQ-020 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-021 cnt width SHALL be $clog2(max(HOLD_CYCLES,STAGE_GAP)+1), and idx width SHALL be $clog2(DOMAIN_COUNT+1); neither wraps past its terminal value.

Reset
REQ-022 While sync_rst is low, on each clk edge: state<=ASSERT, cnt<=0, idx<=0, domain_rst_n_o<=0, seq_busy_o<=1, seq_done_o<=0; this applies regardless of clk_en.
REQ-023 sync_rst asserted mid-RELEASE or in RUN SHALL re-assert every domain on the next edge.
REQ-024 Synchronizer flops have no reset; their contents are don't-care for SYNC_DEPTH cycles after power-up.

Structure
REQ-025 The state enum rst_seq_state_e (ASSERT, RELEASE, RUN) SHALL live in sys_structs alongside clk_dom_sain.
REQ-026 The synchronizer SHALL be an instance of synchronization_chain (CHAIN_DEPTH=SYNC_DEPTH, CHAIN_WIDTH=1); this is the only sub-module.
REQ-027 Elaboration SHALL fail (assertion) if any parameter violates its lower bound.

Verification (defaults, SYNC_DEPTH=3; edge 1 = first edge with sync_rst high, clk_en=1)
REQ-028 Power-up with no requests -> domain_rst_n_o goes 0001 after edge 20, 0011 after 24, 0111 after 28, 1111 after 32; seq_done_o=1 and seq_busy_o=0 after edge 32.
REQ-029 In RUN, pulse sw_rst_req_i for 1 cycle -> all outputs 0 the next edge; the full sequence repeats, domain 0 released 20 edges after the pulse edge.
REQ-030 In RUN, raise async_rst_req_i for 10 cycles -> domains assert SYNC_DEPTH+1 edges after the rise; domain 0 releases 20 edges after the synchronized request falls.
REQ-031 During RELEASE with 0011 released, assert sw_rst_req_i on the cycle domain 2 would release -> 0000, and domain 2 is never released.
REQ-032 Drop clk_en for 7 cycles mid-RELEASE -> outputs and counters hold; every later release is delayed by exactly 7 cycles.
REQ-033 Drop sync_rst in RUN for 1 cycle -> 0000 and seq_done_o=0 the next edge, then the full sequence from edge 1.
